// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/acknowledge bus between the arbiter and the unified memory
interface mem_arbiter_if #(parameter int XLEN = 32);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_be, input mem_ack, mem_rdata);
  modport slave (input mem_req, mem_we, mem_addr, mem_wdata, mem_be, output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data stages with fair alternation
module mem_arbiter #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_flush,
  output logic [31:0]     if_rdata,
  output logic            if_ready,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_be,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_ready,
  output logic            stall_f,
  output logic            stall_m,
  mem_arbiter_if.master   mem
);
  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;
  state_t state_q, state_d;
  logic last_d, discard, grant_f, grant_d, done, if_done, d_done, if_deliver;
  // a requester whose ready pulses this cycle is finishing, so it must not be re-issued
  wire if_elig = if_req && !if_ready && !if_flush;
  wire d_elig = d_req && !d_ready;
  assign stall_f = if_req && !if_ready;
  assign stall_m = d_req && !d_ready;
  assign if_done = done && state_q == IF_BUSY;
  assign d_done = done && state_q == D_BUSY;
  assign if_deliver = if_done && !discard && !if_flush;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // grant decision and next state; last_d hands the tie to fetch after a data grant
  always_comb begin
    grant_d = state_q == IDLE && d_elig && (!if_elig || !last_d);
    grant_f = state_q == IDLE && if_elig && !grant_d;
    done = state_q != IDLE && mem.mem_ack;
    state_d = grant_d ? D_BUSY : grant_f ? IF_BUSY : done ? IDLE : state_q;
  end
  // registered bus fields, ready pulses and returned data
  always_ff @(posedge clk) begin
    if (rst) begin
      mem.mem_req <= 1'b0;
      mem.mem_we <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_wdata <= '0;
      mem.mem_be <= 4'h0;
      if_ready <= 1'b0;
      d_ready <= 1'b0;
      if_rdata <= '0;
      d_rdata <= '0;
      discard <= 1'b0;
      last_d <= 1'b0;
    end else begin
      if_ready <= if_deliver;
      d_ready <= d_done;
      if (grant_f || grant_d) begin
        mem.mem_req <= 1'b1;
        mem.mem_we <= grant_d && d_we;
        mem.mem_addr <= grant_d ? d_addr : if_addr;
        mem.mem_be <= grant_d ? d_be : 4'hF;
        last_d <= grant_d;
      end
      if (grant_d) mem.mem_wdata <= d_wdata;
      if (done) begin
        mem.mem_req <= 1'b0;
        mem.mem_we <= 1'b0;
      end
      if (state_q == IF_BUSY) discard <= !done && (discard || if_flush);
      if (if_deliver) if_rdata <= mem.mem_rdata[31:0];
      if (d_done) d_rdata <= mem.mem_rdata;
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares a single-port unified instruction/data memory between the fetch stage and the memory stage. It serialises transactions onto a request/acknowledge memory bus with arbitrary wait states. It returns read data with a ready pulse and drops fetch results cancelled by a redirect. It also produces the stall signals the hazard logic uses to freeze IF and MEM while their access is outstanding.

## Interface
- XLEN, 32, address/data width

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch wants instruction at if_addr; held until if_ready
- if_addr  in  XLEN  fetch byte address (PCF)
- if_flush  in  1  redirect (PCSrcE); cancels the current fetch
- if_rdata  out  32  instruction word, valid while if_ready=1
- if_ready  out  1  one-cycle pulse, fetch complete
- d_req  in  1  data access request; held until d_ready
- d_we  in  1  1=store, 0=load
- d_addr  in  XLEN  data byte address
- d_wdata  in  XLEN  store data
- d_be  in  4  byte enables for stores
- d_rdata  out  XLEN  load data, valid while d_ready=1
- d_ready  out  1  one-cycle pulse, data access complete
- stall_f  out  1  if_req & ~if_ready
- stall_m  out  1  d_req & ~d_ready
- mem_req  out  1  memory transaction valid; held until mem_ack
- mem_we, mem_addr, mem_wdata, mem_be  out  1/XLEN/XLEN/4  transaction fields; stable while mem_req=1
- mem_ack  in  1  memory completes the transaction this cycle
- mem_rdata  in  XLEN  read data, valid with mem_ack

## Operation
- States: IDLE, IF_BUSY, D_BUSY.
- In IDLE, a requester is eligible when its req=1 and its ready output is 0 in that cycle. This prevents re-issuing a request that completes this cycle.
- Fetch is additionally ineligible in any cycle with if_flush=1.
- Arbitration when both are eligible: data wins, unless last_d=1, in which case fetch wins. last_d is set on each granted data access and cleared on each granted fetch. This guarantees alternation and prevents fetch starvation.
- On grant, mem_req is registered to 1 and the fields are latched:
  - fetch grant: mem_we=0, mem_be=4'hF
  - data grant: d_we, d_be, d_wdata are copied
- The state moves to IF_BUSY or D_BUSY.
- In BUSY, mem_req and all fields hold until mem_ack.
- On mem_ack:
  - mem_req goes to 0 and the state returns to IDLE.
  - The matching ready and rdata are registered, pulsing for exactly one cycle.
  - mem_we is cleared to 0.
- Flush: if_flush=1 in IF_BUSY sets discard. The transaction still completes, because the memory bus cannot be aborted.
  - On its mem_ack, if_ready stays 0 and discard clears.
  - if_flush coincident with mem_ack also suppresses if_ready.
  - A flush in IDLE or D_BUSY has no effect beyond blocking fetch eligibility that cycle.
- if_flush never affects a data transaction.
- mem_rdata is sampled only on mem_ack. if_rdata and d_rdata hold their last value otherwise.
- stall_f and stall_m are combinational from req and ready.

## Timing
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_be 0, if_ready 0, d_ready 0, if_rdata 0, d_rdata 0, discard 0, last_d 0.
- Minimum latency:
  - req seen in cycle N
  - mem_req=1 in N+1
  - mem_ack in N+1
  - ready pulse in N+2
- Each mem_ack wait state adds one cycle.
- The next grant can occur in the same cycle that a ready pulse is driven. mem_req is therefore 0 for exactly one cycle between back-to-back transactions.
- Reset mid-transaction: everything returns to reset values on the next edge, and a pending mem_ack is ignored. Memory is reset by the same rst.
- Address wrap: no arithmetic is performed; addresses pass through unchanged, including 32'hFFFF_FFFC.

## Test plan
- Fetch only: if_req=1, if_addr=0x00000010, mem_ack one cycle after mem_req with mem_rdata=0x00500093 -> mem_addr=0x10, mem_be=4'hF, if_ready pulses 1 cycle with if_rdata=0x00500093, stall_f=1 until then.
- Both pending from reset: d_req load at 0x100, if_req at 0x4 -> data served first (mem_addr=0x100), then fetch (0x4); with both held continuously, grants alternate D,F,D,F.
- Store: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_be=4'b0011, 3 wait states -> mem fields held for 4 cycles, d_ready on the cycle after mem_ack, mem_we returns to 0.
- Flush in flight: fetch 0x8 granted, if_flush=1 on the cycle before mem_ack -> no if_ready. A subsequent if_req at 0x40 is served normally.
- Flush coincident with mem_ack and with an IDLE request -> neither produces if_ready or a grant that cycle.
- rst asserted during D_BUSY with mem_ack arriving the same cycle -> all outputs at reset values next cycle, no d_ready.
